// File: rtl/mc_controller.sv
// mc_controller -- multicycle control unit for the ARM-subset processor.
//
// Sequences the shared datapath through per-instruction state sequences,
// holds the NZCV flags register and evaluates each instruction's condition
// field in DECODE against the registered flags.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   instr[31:0] in   instruction register (cond, op, funct used)
//   alu_flags   in   NZCV produced by the ALU this cycle
//   pc_we       out  PC register load
//   ir_we       out  instruction register load
//   adr_src     out  memory address select (0 = PC, 1 = ALUOut)
//   mem_we      out  data memory write
//   rf_we       out  regfile write to Rd
//   alu_src_a   out  ALU A select (00 RD1, 01 PC, 10 ALUOut)
//   alu_src_b   out  ALU B select (00 RD2, 01 ext, 10 constant 4)
//   alu_ctrl    out  ALU op (00 ADD, 01 SUB, 10 AND, 11 ORR)
//   result_src  out  write-back/PC source (00 ALUOut, 01 Data, 10 ALU direct)
//   imm_src     out  extend mode (00 imm8, 01 imm12, 10 simm24<<2)
//   flags       out  registered NZCV
//   instr_done  out  one-cycle pulse in the final cycle of each instruction
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    output logic        pc_we,
    output logic        ir_we,
    output logic        adr_src,
    output logic        mem_we,
    output logic        rf_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_ctrl,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic [3:0]  flags,
    output logic        instr_done
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flags_q, flags_d;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        cond_ok;
    logic [1:0]  dp_ctrl;
    logic        dp_supported;
    logic        dp_is_cmp;

    // Only the decode fields above are needed by the controller.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^instr[19:0];

    assign cond  = instr[31:28];
    assign op    = instr[27:26];
    assign funct = instr[25:20];
    assign flags = flags_q;

    // Condition evaluation; f is NZCV.
    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_check = z;
            4'b0001: cond_check = !z;
            4'b0010: cond_check = cy;
            4'b0011: cond_check = !cy;
            4'b0100: cond_check = n;
            4'b0101: cond_check = !n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = !v;
            4'b1000: cond_check = cy && !z;
            4'b1001: cond_check = !cy || z;
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = !z && (n == v);
            4'b1101: cond_check = z || (n != v);
            4'b1110: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

    assign cond_ok = cond_check(cond, flags_q);

    // Data-processing opcode decode; unsupported opcodes run as a
    // flag-less, write-less ADD.
    always_comb begin
        dp_ctrl      = 2'b00;
        dp_supported = 1'b1;
        dp_is_cmp    = 1'b0;
        case (funct[4:1])
            4'b0100: dp_ctrl = 2'b00;
            4'b0010: dp_ctrl = 2'b01;
            4'b0000: dp_ctrl = 2'b10;
            4'b1100: dp_ctrl = 2'b11;
            4'b1010: begin
                dp_ctrl   = 2'b01;
                dp_is_cmp = 1'b1;
            end
            default: dp_supported = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        adr_src    = 1'b0;
        mem_we     = 1'b0;
        rf_we      = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 2'b00;
        result_src = 2'b00;
        imm_src    = 2'b00;
        instr_done = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures PC+8 here: R15 and the branch base.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                case (op)
                    2'b01:   imm_src = 2'b01;
                    2'b10:   imm_src = 2'b10;
                    default: imm_src = 2'b00;
                endcase
                if (!cond_ok || op == 2'b11) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (op == 2'b01) begin
                    state_d = S_MEMADR;
                end else if (op == 2'b10) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d = funct[5] ? S_EXECI : S_EXECR;
                end
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                imm_src   = 2'b01;
                alu_ctrl  = funct[3] ? 2'b00 : 2'b01;
                state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                rf_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_ctrl  = dp_ctrl;
                if (funct[0] && dp_supported) begin
                    flags_d = alu_flags;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we      = dp_supported && !dp_is_cmp;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Suppress architectural writes while reset is held mid-instruction.
        if (reset) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            mem_we = 1'b0;
            rf_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

endmodule
